// File: rtl/alu_issue_if.sv
// Instruction handshake and external ALU bus for the alu_issue stage.
// The slave view belongs to the issue stage; the master view belongs to the environment that feeds it.
interface alu_issue_if;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;

    modport master (
        output instr_valid, instr, alu_result, alu_zero, alu_carry, alu_overflow,
        input  instr_ready, alu_a, alu_b, alu_opcode
    );

    modport slave (
        input  instr_valid, instr, alu_result, alu_zero, alu_carry, alu_overflow,
        output instr_ready, alu_a, alu_b, alu_opcode
    );
endinterface

// File: rtl/alu_issue.sv
// Single-issue ALU stage: reads operands from a 4 x 8-bit register file, drives an
// external ALU, then writes back the result and flags before accepting the next instruction.
module alu_issue (
    input  logic        clock,
    input  logic        reset,
    alu_issue_if.slave  bus,
    input  logic        ld_en,
    input  logic [1:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        FLAGS = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;
    logic [7:0]  regs_r [4];
    logic [7:0]  alu_a_r;
    logic [7:0]  alu_b_r;
    logic [1:0]  alu_opcode_r;
    logic [1:0]  rd_r;
    logic [7:0]  result_r;
    logic        flag_z_r;
    logic        flag_c_r;
    logic        flag_v_r;
    logic        done_r;

    // Next-state decode and the accept strobe.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.instr_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC:    state_next_s = FLAGS;
            FLAGS:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, operand latches, result capture and architectural writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            alu_a_r      <= 8'h00;
            alu_b_r      <= 8'h00;
            alu_opcode_r <= 2'b00;
            rd_r         <= 2'b00;
            result_r     <= 8'h00;
            flag_z_r     <= 1'b0;
            flag_c_r     <= 1'b0;
            flag_v_r     <= 1'b0;
            done_r       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_r == FLAGS);
            // Operands come from the pre-edge register file, so a same-edge load is not seen.
            if (accept_s) begin
                alu_a_r      <= regs_r[bus.instr[3:2]];
                alu_b_r      <= regs_r[bus.instr[1:0]];
                alu_opcode_r <= bus.instr[7:6];
                rd_r         <= bus.instr[5:4];
            end
            if (state_r == EXEC) begin
                result_r <= bus.alu_result;
            end
            if (ld_en) begin
                regs_r[ld_addr] <= ld_data;
            end
            // Placed after the host load so the writeback wins on a shared target.
            if (state_r == FLAGS) begin
                regs_r[rd_r] <= result_r;
                flag_z_r     <= bus.alu_zero;
                flag_c_r     <= bus.alu_carry;
                flag_v_r     <= bus.alu_overflow;
            end
        end
    end

    assign bus.instr_ready = (state_r == IDLE) && !reset;
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_opcode  = alu_opcode_r;
    assign dbg_data        = regs_r[dbg_addr];
    assign flag_z          = flag_z_r;
    assign flag_c          = flag_c_r;
    assign flag_v          = flag_v_r;
    assign done            = done_r;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: an environment ALU, a transaction-level model of the
// issue stage checked every cycle, and hand-computed literal expectations.
module tb_alu_issue;

    logic       clock = 1'b0;
    logic       reset;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       flag_z, flag_c, flag_v, done;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    alu_issue_if bus ();

    alu_issue dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .done     (done)
    );

    always #5 clock = ~clock;

    // Environment ALU: 00 AND, 01 OR, 10 ADD, 11 SUB. Returns {v, c, z, result}.
    // ADD carry is the carry into bit 7; SUB carry is the borrow.
    function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        logic [7:0] r;
        logic [7:0] low;
        logic [8:0] sum;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: begin
                sum = {1'b0, a} + {1'b0, b};
                low = {1'b0, a[6:0]} + {1'b0, b[6:0]};
                r   = sum[7:0];
                c   = low[7];
                v   = low[7] ^ sum[8];
            end
            default: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
        endcase
        return {v, c, (r == 8'h00), r};
    endfunction

    logic [10:0] alu_now;
    assign alu_now        = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);
    assign bus.alu_result = alu_now[7:0];

    always @(posedge clock) begin
        bus.alu_zero     <= alu_now[8];
        bus.alu_carry    <= alu_now[9];
        bus.alu_overflow <= alu_now[10];
    end

    // Transaction model: an accepted instruction occupies the stage for two more edges,
    // then commits its result and flags; done follows the commit edge.
    logic [7:0] m_regs [4];
    logic [7:0] m_a, m_b, p_res;
    logic [1:0] m_op, p_rd;
    logic       m_z, m_c, m_v, p_z, p_c, p_v, m_done;
    int         m_busy;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_a = 8'h00; m_b = 8'h00; m_op = 2'b00;
            m_z = 1'b0;  m_c = 1'b0;  m_v = 1'b0;
            m_done = 1'b0;
            m_busy = 0;
        end else begin
            m_done = (m_busy == 1);
            if (m_busy == 0 && bus.instr_valid) begin
                m_a  = m_regs[bus.instr[3:2]];
                m_b  = m_regs[bus.instr[1:0]];
                m_op = bus.instr[7:6];
                p_rd = bus.instr[5:4];
                {p_v, p_c, p_z, p_res} = alu_fn(m_a, m_b, m_op);
                m_busy = 2;
            end else if (m_busy > 0) begin
                m_busy = m_busy - 1;
            end
            if (ld_en) m_regs[ld_addr] = ld_data;
            if (m_done) begin
                m_regs[p_rd] = p_res;
                m_z = p_z; m_c = p_c; m_v = p_v;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, after outputs settle.
    always begin
        @(posedge clock);
        #3;
        if (check_en) begin
            chk("instr_ready", {7'd0, bus.instr_ready}, {7'd0, (m_busy == 0) && !reset});
            chk("done",        {7'd0, done},   {7'd0, m_done});
            chk("alu_a",       bus.alu_a,      m_a);
            chk("alu_b",       bus.alu_b,      m_b);
            chk("alu_opcode",  {6'd0, bus.alu_opcode}, {6'd0, m_op});
            chk("flags",       {5'd0, flag_z, flag_c, flag_v}, {5'd0, m_z, m_c, m_v});
            chk("dbg_data",    dbg_data,       m_regs[dbg_addr]);
        end
    end

    task automatic cyc();
        @(negedge clock);
        dbg_addr = dbg_addr + 2'd1;
    endtask

    task automatic peek(input logic [1:0] addr, input logic [7:0] exp, input string name);
        dbg_addr = addr;
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        cyc();
        ld_en = 1'b0;
    endtask

    // Offers an instruction, waits (bounded) for ready, returns at the first EXEC negedge.
    task automatic issue(input logic [7:0] ins);
        int waited;
        waited = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        while (!bus.instr_ready && waited < 20) begin
            cyc();
            waited++;
        end
        chk("issue_ready_wait", {7'd0, bus.instr_ready}, 8'h01);
        cyc();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00; dbg_addr = 2'd0;
        bus.instr_valid = 1'b0; bus.instr = 8'h00;
        @(posedge clock);
        check_en = 1'b1;
        cyc(); cyc();
        chk("reset_ready", {7'd0, bus.instr_ready}, 8'h00);
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", {7'd0, bus.instr_ready}, 8'h01);

        // ADD R0 = R1 + R2
        load(2'd1, 8'h70);
        load(2'd2, 8'h10);
        issue(8'h86);
        chk("add_alu_a", bus.alu_a, 8'h70);
        chk("add_alu_b", bus.alu_b, 8'h10);
        chk("add_ready_exec", {7'd0, bus.instr_ready}, 8'h00);
        cyc();
        chk("add_op_flags_cycle", {6'd0, bus.alu_opcode}, 8'h02);
        chk("add_done_early", {7'd0, done}, 8'h00);
        cyc();
        chk("add_done", {7'd0, done}, 8'h01);
        chk("add_flags_zcv", {5'd0, flag_z, flag_c, flag_v}, 8'h03);
        peek(2'd0, 8'h80, "add_r0");

        // SUB R3 = R1 - R1
        issue(8'hF5);
        cyc(); cyc();
        chk("sub_flags_zcv", {5'd0, flag_z, flag_c, flag_v}, 8'h04);
        peek(2'd3, 8'h00, "sub_r3");

        // AND with instr_valid held; an OR is queued behind it
        load(2'd1, 8'hF0);
        load(2'd2, 8'h0F);
        bus.instr_valid = 1'b1;
        bus.instr = 8'h06;
        cyc();
        bus.instr = 8'h49;
        chk("and_ready_exec", {7'd0, bus.instr_ready}, 8'h00);
        cyc();
        chk("and_ready_flags", {7'd0, bus.instr_ready}, 8'h00);
        cyc();
        chk("and_done_ready", {6'd0, done, bus.instr_ready}, 8'h03);
        chk("and_flag_z", {7'd0, flag_z}, 8'h01);
        peek(2'd0, 8'h00, "and_r0");
        cyc();
        bus.instr_valid = 1'b0;
        chk("or_alu_a", bus.alu_a, 8'h0F);
        chk("or_alu_b", bus.alu_b, 8'hF0);
        cyc(); cyc();
        peek(2'd0, 8'hFF, "or_r0");

        // Writeback versus host load on R0
        load(2'd1, 8'h70);
        load(2'd2, 8'h10);
        issue(8'h86);
        cyc();
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h55;
        cyc();
        ld_en = 1'b0;
        peek(2'd0, 8'h80, "wb_wins_r0");
        issue(8'h86);
        cyc(); cyc();
        load(2'd0, 8'h55);
        peek(2'd0, 8'h55, "late_load_r0");

        // Reset during EXEC aborts the instruction
        issue(8'h86);
        reset = 1'b1;
        cyc();
        chk("abort_ready_in_reset", {7'd0, bus.instr_ready}, 8'h00);
        reset = 1'b0;
        cyc();
        chk("abort_ready", {7'd0, bus.instr_ready}, 8'h01);
        chk("abort_flags", {5'd0, flag_z, flag_c, flag_v}, 8'h00);
        peek(2'd0, 8'h00, "abort_r0");
        peek(2'd1, 8'h00, "abort_r1");
        cyc(); cyc();
        chk("abort_no_done", {7'd0, done}, 8'h00);

        // Reset beats a same-edge load and accept
        load(2'd3, 8'h33);
        reset = 1'b1; ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
        bus.instr_valid = 1'b1; bus.instr = 8'h86;
        cyc();
        reset = 1'b0; ld_en = 1'b0; bus.instr_valid = 1'b0;
        peek(2'd2, 8'h00, "rst_prio_r2");
        peek(2'd3, 8'h00, "rst_prio_r3");
        chk("rst_prio_ready", {7'd0, bus.instr_ready}, 8'h01);

        // Read-before-write: load R1 on the accept edge
        load(2'd1, 8'h02);
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h01;
        issue(8'h85);
        ld_en = 1'b0;
        cyc(); cyc();
        peek(2'd0, 8'h04, "rbw_r0");
        peek(2'd1, 8'h01, "rbw_r1");

        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL: clock, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL: reset, input, 1, reset is synchronous and active-high.
REQ-003 SHALL: instr_valid, input, 1, instruction offered.
REQ-004 SHALL: instr, input, 8, instruction: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-005 SHALL: instr_ready, output, 1, stage can accept an instruction.
REQ-006 SHALL: ld_en / ld_addr / ld_data, input, 1/2/8, host register-load port.
REQ-007 SHALL: dbg_addr, input, 2, debug read address; dbg_data, output, 8, combinational register-file read.
REQ-008 SHALL: alu_a, alu_b, output, 8 each, ALU operands; alu_opcode, output, 2, ALU operation.
REQ-009 SHALL: alu_result, input, 8, combinational ALU result; alu_zero, alu_carry, alu_overflow, input, 1 each, ALU flags, registered inside the ALU one cycle after the operands.
REQ-010 SHALL: flag_z, flag_c, flag_v, output, 1 each, architectural flags; done, output, 1, one-cycle completion pulse.

Function
REQ-011 SHALL: hold a 4 x 8-bit register file R0..R3; no hard-wired register.
REQ-012 SHALL: implement FSM states IDLE, EXEC, FLAGS.
REQ-013 SHALL: instr_ready = 1 only in IDLE and not in reset.
REQ-014 SHALL: on an edge with instr_valid & instr_ready, latch alu_a=R[rs1], alu_b=R[rs2], alu_opcode=opcode, rd; go to EXEC.
REQ-015 SHALL: in EXEC, capture alu_result into an internal result register at the closing edge; go to FLAGS.
REQ-016 SHALL: in FLAGS, at the closing edge, write the result register to R[rd], load flag_z/flag_c/flag_v from alu_zero/alu_carry/alu_overflow unmodified, and go to IDLE.
REQ-017 SHALL: assert done for exactly the one cycle following the FLAGS edge; instr_ready is also 1 in that cycle, so back-to-back issue takes 3 cycles per instruction.
REQ-018 SHALL: hold alu_a, alu_b, and alu_opcode stable from accept until the next accept, covering the ALU's registered flag cycle.
REQ-019 SHALL: leave flags and the register file unchanged by anything other than a FLAGS-state writeback, a host load, or reset.
REQ-020 SHALL: perform a host load (R[ld_addr] <= ld_data) in any state whenever ld_en = 1.
REQ-021 SHALL: on a same-edge host load and writeback to the same register, the writeback wins.
REQ-022 SHALL: on a host load to rs1/rs2 on the accept edge, capture the pre-load value (read-before-write).
REQ-023 SHALL: for an instruction with rd equal to rs1 or rs2, use the old operand values; rd is updated only at the FLAGS edge.
REQ-024 SHALL: ignore instr_valid outside IDLE; instr is not sampled then.

Reset
REQ-025 SHALL: on reset, set state to IDLE, R0..R3 to 0x00, alu_a/alu_b to 0x00, alu_opcode to 2'b00, result register to 0x00, flags to 0, and done to 0.
REQ-026 SHALL: treat reset in EXEC or FLAGS as an abort: no writeback, no flag update, no done pulse.
REQ-027 SHALL: give reset priority over ld_en and instruction acceptance on the same edge.

Verification
REQ-028 SHALL: load R1=0x70, R2=0x10, issue 0x86 (ADD R0=R1+R2) -> alu_a=0x70, alu_b=0x10, alu_opcode=2'b10 during EXEC/FLAGS; R0=0x80, flag_z=0, flag_c=1, flag_v=1; done 3 cycles after accept.
REQ-029 SHALL: issue 0xF5 (SUB R3=R1-R1) with R1=0x70 -> R3=0x00, flag_z=1, flag_c=0, flag_v=0.
REQ-030 SHALL: load R1=0xF0, R2=0x0F, issue 0x06 (AND R0=R1&R2), hold instr_valid high -> R0=0x00, flag_z=1; a second instruction is accepted only in the done cycle; instr_ready=0 in EXEC/FLAGS.
REQ-031 SHALL: issue 0x86, assert ld_en with ld_addr=0, ld_data=0x55 on the FLAGS edge -> R0 = ALU result (writeback wins); the same load one cycle later -> R0=0x55.
REQ-032 SHALL: assert reset during EXEC after issuing 0x86 -> all registers 0x00, flags 0, no done pulse, instr_ready=1 the cycle after reset deasserts.
REQ-033 SHALL: load R1=0x01 on the same edge as accepting ADD R0=R1+R1 with R1 previously 0x02 -> R0=0x04.
